// File: rtl/mux21_arbiter.sv
// mux21_arbiter: round-robin 2:1 packet arbiter driving a shared mux; MUX21_ARBITER_STATS_EN adds saturating per-requester packet counters
module mux21_arbiter #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_last,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_last,
  output logic              b_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              sel,
  output logic              busy
`ifdef MUX21_ARBITER_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [CNT_W-1:0]  pkt_cnt_a,
  output logic [CNT_W-1:0]  pkt_cnt_b
`endif
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;
  logic [1:0] state;
  logic [1:0] state_nx;
  logic       last_grant;
  assign sel       = (state == GNT1);
  assign busy      = (state != IDLE);
  assign a_ready   = (state == GNT0) && out_ready;
  assign b_ready   = (state == GNT1) && out_ready;
  assign out_valid = (state == GNT0) ? a_valid : (state == GNT1) ? b_valid : 1'b0;
  assign out_data  = sel ? b_data : a_data;
  assign out_last  = sel ? b_last : a_last;
  // on a tie the requester that did not win last time gets the grant
  assign state_nx = (state == IDLE) ?
                      ((a_valid && b_valid) ? (last_grant ? GNT0 : GNT1) :
                       a_valid ? GNT0 : b_valid ? GNT1 : IDLE) :
                    (out_valid && out_ready && out_last) ? IDLE : state;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nx;
      last_grant <= (state == IDLE && state_nx != IDLE) ? (state_nx == GNT1) : last_grant;
    end
  end
`ifdef MUX21_ARBITER_STATS_EN
  logic a_done;
  logic b_done;
  assign a_done = a_valid && a_ready && a_last;
  assign b_done = b_valid && b_ready && b_last;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_a <= '0;
      pkt_cnt_b <= '0;
    end else begin
      pkt_cnt_a <= stats_clr ? '0 : (a_done && !(&pkt_cnt_a)) ? pkt_cnt_a + 1'b1 : pkt_cnt_a;
      pkt_cnt_b <= stats_clr ? '0 : (b_done && !(&pkt_cnt_b)) ? pkt_cnt_b + 1'b1 : pkt_cnt_b;
    end
  end
`else
  localparam int CNT_W_UNUSED = CNT_W;
`endif
endmodule
